// File: rtl/fp_double_multiplier.sv
//============================================================================
// Module : fp_double_multiplier
// Two-pair sequential IEEE-754 binary32 multiplier, round-to-nearest-even.
// Define FP_MUL_FTZ_EN to flush denormal inputs and tiny results to zero.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module fp_double_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] res,
  output logic        done,
  output logic [2:0]  STATE,
  output logic [2:0]  NEXT_STATE
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    ROUND  = 3'd4,
    OUT_A  = 3'd5,
    OUT_B  = 3'd6
  } state_t;

  // Unrounded product: normalised significand with hidden bit at [47].
  typedef struct packed {
    logic        special;
    logic [31:0] spec_val;
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] prod;
  } mid_t;

  // Returns {exponent(10, two's complement), significand(24)} with bit 23 set.
  function automatic logic [33:0] prenorm(input logic [30:0] x);
    logic [23:0] mant;
    logic [9:0]  expo;
    logic [4:0]  lz;
    logic        found;
    mant  = {x[30:23] != 8'd0, x[22:0]};
    expo  = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (mant[i]) found = 1'b1;
      else if (!found) lz = lz + 5'd1;
    end
    return {expo - {5'd0, lz}, mant << lz};
  endfunction

  function automatic mid_t mul_stage(input logic [31:0] a, input logic [31:0] b);
    mid_t        m;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [33:0] na, nb;
    logic [9:0]  e;
    logic [47:0] p;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
`ifdef FP_MUL_FTZ_EN
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
`else
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
`endif
    na = prenorm(a[30:0]);
    nb = prenorm(b[30:0]);
    e  = na[33:24] + nb[33:24] - 10'd127;
    p  = {24'd0, na[23:0]} * {24'd0, nb[23:0]};
    if (p[47]) e = e + 10'd1;
    else       p = p << 1;
    m.special = 1'b1;
    m.sign    = a[31] ^ b[31];
    m.exp     = e;
    m.prod    = p;
    if (a_nan)                                       m.spec_val = a;
    else if (b_nan)                                  m.spec_val = b;
    else if ((a_inf && b_zero) || (a_zero && b_inf)) m.spec_val = 32'hFFC00000;
    else if (a_inf || b_inf)                         m.spec_val = {m.sign, 8'hFF, 23'd0};
    else if (a_zero || b_zero)                       m.spec_val = {m.sign, 31'd0};
    else begin
      m.special  = 1'b0;
      m.spec_val = 32'd0;
    end
    return m;
  endfunction

  function automatic logic [31:0] round_stage(input mid_t m);
    logic signed [9:0] e;
    logic [9:0]        sh;
    logic [47:0]       p;
    logic [95:0]       wide;
    logic              sticky, up;
    logic [24:0]       kr;
    logic [31:0]       r;
    e      = $signed(m.exp);
    p      = m.prod;
    sticky = 1'b0;
    // Tiny results are denormalised first so that rounding happens at 2^-149.
    if (e < 10'sd1) begin
      sh = 10'd1 - m.exp;
      if (sh > 10'd48) sh = 10'd48;
      wide   = {p, 48'd0} >> sh;
      p      = wide[95:48];
      sticky = |wide[47:0];
      e      = 10'sd0;
    end
    sticky = sticky | (|p[22:0]);
    up     = p[23] & (sticky | p[24]);
    kr     = {1'b0, p[47:24]} + {24'd0, up};
    if (e == 10'sd0) begin
      // A carry into kr[23] lands exactly on the minimum normal encoding.
      r = {m.sign, 7'd0, kr[23:0]};
`ifdef FP_MUL_FTZ_EN
      if (!kr[23]) r = {m.sign, 31'd0};
`endif
    end else begin
      if (kr[24]) e = e + 10'sd1;
      if (e >= 10'sd255) r = {m.sign, 8'hFF, 23'd0};
      else               r = {m.sign, e[7:0], kr[22:0]};
    end
    if (m.special) r = m.spec_val;
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [63:0] op_a_q, op_a_d, op_b_q, op_b_d;
  mid_t        mid_a_q, mid_a_d, mid_b_q, mid_b_d;
  logic [31:0] rnd_a_q, rnd_a_d, rnd_b_q, rnd_b_d;
  logic [31:0] res_q, res_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    mid_a_d = mid_a_q;
    mid_b_d = mid_b_q;
    rnd_a_d = rnd_a_q;
    rnd_b_d = rnd_b_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:   if (ready) state_d = LOAD_A;
      LOAD_A: begin
        op_a_d  = {op1, op2};
        state_d = LOAD_B;
      end
      LOAD_B: begin
        op_b_d  = {op1, op2};
        state_d = CALC;
      end
      CALC: begin
        mid_a_d = mul_stage(op_a_q[63:32], op_a_q[31:0]);
        mid_b_d = mul_stage(op_b_q[63:32], op_b_q[31:0]);
        state_d = ROUND;
      end
      ROUND: begin
        rnd_a_d = round_stage(mid_a_q);
        rnd_b_d = round_stage(mid_b_q);
        state_d = OUT_A;
      end
      OUT_A: begin
        res_d   = rnd_a_q;
        done_d  = 1'b1;
        state_d = OUT_B;
      end
      OUT_B: begin
        res_d   = rnd_b_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      mid_a_q <= '0;
      mid_b_q <= '0;
      rnd_a_q <= '0;
      rnd_b_q <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      mid_a_q <= mid_a_d;
      mid_b_q <= mid_b_d;
      rnd_a_q <= rnd_a_d;
      rnd_b_q <= rnd_b_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign res        = res_q;
  assign done       = done_q;
  assign STATE      = state_q;
  assign NEXT_STATE = state_d;

endmodule

`default_nettype wire

// File: tb/tb_fp_double_multiplier.sv
//============================================================================
// Module : tb_fp_double_multiplier
// Randomised and directed bench for fp_double_multiplier with a real-valued model.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_fp_double_multiplier;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] op1   = '0;
  logic [31:0] op2   = '0;
  logic [31:0] res;
  logic        done;
  logic [2:0]  STATE;
  logic [2:0]  NEXT_STATE;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_q[$];

  fp_double_multiplier dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .op1        (op1),
    .op2        (op2),
    .res        (res),
    .done       (done),
    .STATE      (STATE),
    .NEXT_STATE (NEXT_STATE)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, got, want);
  endtask

  // Exact magnitude of a finite binary32 encoding.
  function automatic real to_real(input logic [31:0] x);
    int e;
    int f;
    real r;
    e = int'(x[30:23]);
    f = int'(x[22:0]);
    if (e == 0) r = f * (2.0 ** (-149));
    else        r = (f + 8388608) * (2.0 ** (e - 150));
    return r;
  endfunction

  // Product computed exactly in double precision, then rounded to binary32 (RNE).
  function automatic logic [31:0] model_mul(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a, b, r;
    logic        s, a_inf, b_inf, a_zero, b_zero;
    logic [63:0] d, dm, q, rem, half;
    real         p;
    int          ex, sh;
    a = a_in;
    b = b_in;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF && a[22:0] != 0) return a;
    if (b[30:23] == 8'hFF && b[22:0] != 0) return b;
`ifdef FP_MUL_FTZ_EN
    if (a[30:23] == 8'd0) a[22:0] = '0;
    if (b[30:23] == 8'd0) b[22:0] = '0;
`endif
    a_inf  = (a[30:0] == 31'h7F800000);
    b_inf  = (b[30:0] == 31'h7F800000);
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    if ((a_inf && b_zero) || (a_zero && b_inf)) return 32'hFFC00000;
    if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {s, 31'd0};
    p  = to_real(a) * to_real(b);
    d  = $realtobits(p);
    ex = int'(d[62:52]) - 1023;
    dm = {12'd1, d[51:0]};
    sh = (ex < -126) ? 29 + (-126 - ex) : 29;
    if (sh > 62) q = 64'd0;
    else begin
      q    = dm >> sh;
      rem  = dm - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    end
    if (ex >= -126) begin
      if (q == 64'h1000000) begin
        q  = 64'h800000;
        ex = ex + 1;
      end
      if (ex + 127 >= 255) r = {s, 8'hFF, 23'd0};
      else                 r = {s, 8'(ex + 127), q[22:0]};
    end else begin
      r = {s, q[30:0]};
    end
`ifdef FP_MUL_FTZ_EN
    if (r[30:23] == 8'd0) r = {s, 31'd0};
`endif
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      2, 3:    x[30:23] = 8'($urandom_range(0, 30));
      4, 5:    x[30:23] = 8'($urandom_range(90, 140));
      6:       x[30:23] = 8'($urandom_range(200, 254));
      7:       x[30:23] = 8'd0;
      8:       x[30:0]  = ($urandom_range(0, 1) == 1) ? 31'h7F800000 : 31'd0;
      9:       x[30:23] = 8'hFF;
      default: x = x;
    endcase
    return x;
  endfunction

  // One request: ready pulse, pair A, pair B, then wait until back in IDLE.
  task automatic run_req(input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] b1, input logic [31:0] b2, input bit chk);
    ready = 1'b1;
    if (chk) begin
      #1;
      check("next_state_idle", {29'd0, NEXT_STATE}, 32'd1);
      check("state_idle", {29'd0, STATE}, 32'd0);
    end
    @(negedge clk);
    if (chk) check("state_load_a", {29'd0, STATE}, 32'd1);
    ready = 1'b0;
    op1   = a1;
    op2   = a2;
    @(negedge clk);
    if (chk) check("state_load_b", {29'd0, STATE}, 32'd2);
    op1 = b1;
    op2 = b2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (chk) check("state_seq", {29'd0, STATE}, 32'(3 + i));
      ready = 1'($urandom_range(0, 1));
      op1   = $urandom;
      op2   = $urandom;
    end
    @(negedge clk);
    if (chk) check("state_back_idle", {29'd0, STATE}, 32'd0);
    ready = 1'b0;
  endtask

`ifdef FP_MUL_FTZ_EN
  localparam logic [31:0] E4B = 32'h00000000, E5B = 32'h00000000, E6A = 32'h00000000,
                          E7B = 32'h00000000, E8A = 32'h00000000;
`else
  localparam logic [31:0] E4B = 32'h00000008, E5B = 32'h00400000, E6A = 32'h00600000,
                          E7B = 32'h00000002, E8A = 32'h00800000;
`endif

  // {a1, a2, expected A, b1, b2, expected B}
  logic [191:0] lits [9] = '{
    {32'h00000000, 32'hFF800000, 32'hFFC00000, 32'h7F800000, 32'h00000000, 32'hFFC00000},
    {32'h7F800006, 32'h3FA00000, 32'h7F800006, 32'h3FA00000, 32'h7F800006, 32'h7F800006},
    {32'h80000000, 32'h3FA00000, 32'h80000000, 32'h60000000, 32'h60000000, 32'h7F800000},
    {32'h42F778F2, 32'h3AA137F4, 32'h3E1BD927, 32'h4291CCCD, 32'h41100000, 32'h44240667},
    {32'h407FFFFE, 32'h40000001, 32'h41000000, 32'h41000000, 32'h00000001, E4B},
    {32'h00400000, 32'h00400000, 32'h00000000, 32'h3C000000, 32'h03800000, E5B},
    {32'h3FC00000, 32'h00400000, E6A,          32'h00000001, 32'h3F000000, 32'h00000000},
    {32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 32'h00000003, 32'h3F000000, E7B},
    {32'h007FFFFF, 32'h3F800001, E8A,          32'h7F7FFFFF, 32'h3F800001, 32'h7F800000}
  };

  // Compare process: every done cycle pops one expected product, otherwise res must hold.
  initial begin
    logic [31:0] hold;
    logic [31:0] want;
    hold = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = '0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", {31'd0, done}, 32'd0);
        end else begin
          want = exp_q.pop_front();
          check("res", res, want);
          hold = want;
        end
      end else begin
        check("res_hold", res, hold);
      end
    end
  end

  initial begin
    logic [191:0] row;
    logic [31:0]  a1, a2, b1, b2;

    repeat (2) @(negedge clk);
    check("reset_res", res, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_state", {29'd0, STATE}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      row = lits[i];
      check("model_pin_a", model_mul(row[191:160], row[159:128]), row[127:96]);
      check("model_pin_b", model_mul(row[95:64], row[63:32]), row[31:0]);
      exp_q.push_back(row[127:96]);
      exp_q.push_back(row[31:0]);
      run_req(row[191:160], row[159:128], row[95:64], row[63:32], i == 0);
    end

    // Reset while in CALC abandons the request.
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    op1   = 32'h3F800000;
    op2   = 32'h40000000;
    @(negedge clk);
    op1 = 32'h40400000;
    op2 = 32'h40400000;
    @(negedge clk);
    check("state_calc", {29'd0, STATE}, 32'd3);
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_reset_state", {29'd0, STATE}, 32'd0);
    check("mid_reset_done", {31'd0, done}, 32'd0);
    check("mid_reset_res", res, 32'd0);
    #2 rst = 1'b1;
    repeat (6) @(negedge clk);
    check("after_reset_state", {29'd0, STATE}, 32'd0);

    for (int n = 0; n < 250; n++) begin
      a1 = rand_op();
      a2 = rand_op();
      b1 = rand_op();
      b2 = rand_op();
      exp_q.push_back(model_mul(a1, a2));
      exp_q.push_back(model_mul(b1, b2));
      run_req(a1, a2, b1, b2, 1'b0);
    end

    repeat (4) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
